// File: rtl/fe_fetch.sv
// eZ90 fetch front end: owns the fetch PC, issues in-order 32-bit fetches, queues tagged responses.
// Optional macro EZ90_FETCH_BYPASS_EN lets a response reach inst_* in its own cycle when the queue is empty.
module fe_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_fault,
    output logic        inst_valid,
    output logic [63:0] inst_pc,
    output logic [31:0] inst_word,
    output logic        inst_fault,
    input  logic        inst_ready
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [63:0] RESET_PC_AL = RESET_PC & ~64'h3;

    logic [63:0]   fetch_pc;
    logic          halted;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] q_count;
    logic [AW-1:0] pend_wr, pend_rd, q_wr, q_rd;

    logic [63:0] pend_pc [QDEPTH];
    logic [63:0] q_pc    [QDEPTH];
    logic [31:0] q_word  [QDEPTH];
    logic        q_fault [QDEPTH];

    logic [CW:0]   credit_used;
    logic          req_fire;
    logic [63:0]   rsp_pc;
    logic [31:0]   rsp_word;
    logic          rsp_keep;
    logic          byp_active;
    logic          q_push;
    logic          q_pop;

    // Outstanding fetches plus queued entries never exceed QDEPTH, so the queue cannot overflow.
    assign credit_used   = {1'b0, outstanding} + {1'b0, q_count};
    assign mem_req_valid = rst_n && !halted && !redirect_valid && (credit_used < (CW+1)'(QDEPTH));
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign rsp_pc   = pend_pc[pend_rd];
    assign rsp_word = mem_rsp_fault ? 32'h0 : mem_rsp_data;
    assign rsp_keep = mem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

`ifdef EZ90_FETCH_BYPASS_EN
    assign byp_active = rsp_keep && (q_count == '0);
`else
    assign byp_active = 1'b0;
`endif

    assign q_pop  = (q_count != '0) && inst_ready && !redirect_valid;
    assign q_push = rsp_keep && !(byp_active && inst_ready);

    always_comb begin
        inst_valid = 1'b0;
        inst_pc    = 64'h0;
        inst_word  = 32'h0;
        inst_fault = 1'b0;
        if (q_count != '0) begin
            inst_valid = 1'b1;
            inst_pc    = q_pc[q_rd];
            inst_word  = q_word[q_rd];
            inst_fault = q_fault[q_rd];
        end else if (byp_active) begin
            inst_valid = 1'b1;
            inst_pc    = rsp_pc;
            inst_word  = rsp_word;
            inst_fault = mem_rsp_fault;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC_AL;
            halted      <= 1'b0;
            outstanding <= '0;
            drop_cnt    <= '0;
            q_count     <= '0;
            pend_wr     <= '0;
            pend_rd     <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(mem_rsp_valid);
            if (req_fire)
                pend_wr <= pend_wr + AW'(1);
            if (mem_rsp_valid)
                pend_rd <= pend_rd + AW'(1);
            if (redirect_valid) begin
                // Every fetch still in flight after this cycle's retirement belongs to the old path.
                fetch_pc <= redirect_pc & ~64'h3;
                halted   <= 1'b0;
                drop_cnt <= outstanding - CW'(mem_rsp_valid);
                q_count  <= '0;
                q_wr     <= '0;
                q_rd     <= '0;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 64'd4;
                if (mem_rsp_valid && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CW'(1);
                if (rsp_keep && mem_rsp_fault)
                    halted <= 1'b1;
                if (q_push)
                    q_wr <= q_wr + AW'(1);
                if (q_pop)
                    q_rd <= q_rd + AW'(1);
                case ({q_push, q_pop})
                    2'b10:   q_count <= q_count + CW'(1);
                    2'b01:   q_count <= q_count - CW'(1);
                    default: q_count <= q_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            pend_pc[pend_wr] <= fetch_pc;
        if (q_push) begin
            q_pc[q_wr]    <= rsp_pc;
            q_word[q_wr]  <= rsp_word;
            q_fault[q_wr] <= mem_rsp_fault;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(q_push && !q_pop && (q_count == CW'(QDEPTH))))
        else $error("fe_fetch instruction queue overflow");

endmodule

// File: tb/tb_fe_fetch.sv
// Scoreboard bench for fe_fetch: in-order memory model with programmable latency and fault address.
module tb_fe_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_fault;
    logic        inst_valid;
    logic [63:0] inst_pc;
    logic [31:0] inst_word;
    logic        inst_fault;
    logic        inst_ready;

    logic        w_req_valid;
    logic [63:0] w_req_addr;
    logic        w_inst_valid;
    logic [63:0] w_inst_pc;
    logic [31:0] w_inst_word;
    logic        w_inst_fault;

`ifdef EZ90_FETCH_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif

    always #5 clk = ~clk;

    fe_fetch #(.RESET_PC(64'h100), .QDEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_fault(mem_rsp_fault),
        .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_word(inst_word), .inst_fault(inst_fault),
        .inst_ready(inst_ready)
    );

    fe_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .QDEPTH(4)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(w_req_valid), .mem_req_addr(w_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_fault(mem_rsp_fault),
        .inst_valid(w_inst_valid), .inst_pc(w_inst_pc), .inst_word(w_inst_word), .inst_fault(w_inst_fault),
        .inst_ready(inst_ready)
    );

    typedef struct { logic [63:0] pc; logic [31:0] word; logic fault; } exp_t;
    typedef struct { logic [63:0] addr; int due; } pend_t;

    exp_t        exp_q[$];
    pend_t       mem_pend[$];
    logic [63:0] acc_log[$];
    logic [63:0] inst_log[$];
    logic [63:0] w_acc_log[$];
    logic [63:0] w_inst_log[$];
    logic [31:0] w_word_log[$];
    logic        w_fault_seen;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          rsp_lat;
    int          first_acc_cyc, first_inst_cyc;
    logic [63:0] model_pc, fault_addr;
    logic [63:0] fault_pc_seen;
    logic [31:0] fault_word_seen;

    logic        s_req_valid, s_inst_valid, s_inst_fault;
    logic [63:0] s_inst_pc;
    logic [31:0] s_inst_word;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ {a[15:0], 16'h0} ^ 32'hC0DE_0000;
    endfunction

    // One clock: sample and score at negedge, then drive the next cycle's inputs after posedge.
    task automatic cycle();
        exp_t  e;
        pend_t p;
        @(negedge clk);
        s_req_valid  = mem_req_valid;
        s_inst_valid = inst_valid;
        s_inst_pc    = inst_pc;
        s_inst_word  = inst_word;
        s_inst_fault = inst_fault;
        if (w_req_valid && mem_req_ready) w_acc_log.push_back(w_req_addr);
        if (w_inst_valid && inst_ready && !redirect_valid) begin
            w_inst_log.push_back(w_inst_pc);
            w_word_log.push_back(w_inst_word);
            if (w_inst_fault) w_fault_seen = 1'b1;
        end
        if (redirect_valid) begin
            checks++;
            if (mem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL redirect_no_req: mem_req_valid=%b required 0", mem_req_valid);
            end
            exp_q.delete();
            model_pc = redirect_pc & ~64'h3;
        end else begin
            if (inst_valid && inst_ready) begin
                inst_log.push_back(inst_pc);
                if (inst_log.size() == 1) first_inst_cyc = cyc;
                if (inst_fault) begin
                    fault_pc_seen   = inst_pc;
                    fault_word_seen = inst_word;
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL inst_unexpected: got pc=%h, required no instruction", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (inst_pc !== e.pc || inst_word !== e.word || inst_fault !== e.fault) begin
                        errors++;
                        $display("FAIL inst_entry: got pc=%h word=%h fault=%b, required pc=%h word=%h fault=%b",
                                 inst_pc, inst_word, inst_fault, e.pc, e.word, e.fault);
                    end
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                checks++;
                if (mem_req_addr !== model_pc) begin
                    errors++;
                    $display("FAIL req_addr: got %h, required %h", mem_req_addr, model_pc);
                end
                acc_log.push_back(mem_req_addr);
                if (acc_log.size() == 1) first_acc_cyc = cyc;
                e.pc    = model_pc;
                e.fault = (model_pc == fault_addr);
                e.word  = e.fault ? 32'h0 : word_of(model_pc);
                exp_q.push_back(e);
                p.addr = mem_req_addr;
                p.due  = cyc + rsp_lat;
                mem_pend.push_back(p);
                model_pc = model_pc + 64'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        if (mem_pend.size() > 0 && mem_pend[0].due <= cyc) begin
            p = mem_pend.pop_front();
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = word_of(p.addr);
            mem_rsp_fault = (p.addr == fault_addr);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'h0;
            mem_rsp_fault = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 32'h0;
        mem_rsp_fault  = 1'b0;
        inst_ready     = 1'b0;
        exp_q.delete();
        mem_pend.delete();
        acc_log.delete();
        inst_log.delete();
        w_acc_log.delete();
        w_inst_log.delete();
        w_word_log.delete();
        w_fault_seen    = 1'b0;
        model_pc        = 64'h100;
        fault_addr      = 64'h1;
        rsp_lat         = 1;
        first_acc_cyc   = -1;
        first_inst_cyc  = -1;
        fault_pc_seen   = '1;
        fault_word_seen = '1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic end_drain(input string name);
        int n = 0;
        mem_req_ready = 1'b0;
        inst_ready    = 1'b1;
        while ((exp_q.size() != 0 || mem_pend.size() != 0) && n < 40) begin
            cycle();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || mem_pend.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d instructions still expected, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
        mem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        checks += 6;
        if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b, required 0", mem_req_valid); end
        if (mem_req_addr !== 64'h100) begin errors++; $display("FAIL rst_req_addr: got %h, required 100", mem_req_addr); end
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b, required 0", inst_valid); end
        if (inst_pc !== 64'h0) begin errors++; $display("FAIL rst_inst_pc: got %h, required 0", inst_pc); end
        if (inst_word !== 32'h0) begin errors++; $display("FAIL rst_inst_word: got %h, required 0", inst_word); end
        if (inst_fault !== 1'b0) begin errors++; $display("FAIL rst_inst_fault: got %b, required 0", inst_fault); end
    endtask

    task automatic test_stream();
        logic [63:0] want;
        apply_reset();
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
        repeat (8) cycle();
        for (int i = 0; i < 3; i++) begin
            want = 64'h100 + 64'(4 * i);
            checks++;
            if (i >= acc_log.size() || acc_log[i] !== want) begin
                errors++;
                $display("FAIL stream_addr%0d: got %h, required %h", i, (i < acc_log.size()) ? acc_log[i] : 64'hx, want);
            end
            checks++;
            if (i >= inst_log.size() || inst_log[i] !== want) begin
                errors++;
                $display("FAIL stream_pc%0d: got %h, required %h", i, (i < inst_log.size()) ? inst_log[i] : 64'hx, want);
            end
        end
        end_drain("stream");
    endtask

    task automatic test_backpressure();
        logic        held = 1'b0;
        logic [63:0] h_pc;
        logic [31:0] h_word;
        logic        h_fault;
        apply_reset();
        mem_req_ready = 1'b1;
        inst_ready    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_inst_valid) begin
                if (!held) begin
                    held = 1'b1; h_pc = s_inst_pc; h_word = s_inst_word; h_fault = s_inst_fault;
                end else begin
                    checks++;
                    if (s_inst_pc !== h_pc || s_inst_word !== h_word || s_inst_fault !== h_fault) begin
                        errors++;
                        $display("FAIL bp_stable: got pc=%h word=%h, required pc=%h word=%h", s_inst_pc, s_inst_word, h_pc, h_word);
                    end
                end
            end
        end
        checks += 2;
        if (acc_log.size() != 4) begin errors++; $display("FAIL bp_accepts: got %0d, required 4", acc_log.size()); end
        if (s_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_held: got %b, required 0", s_req_valid); end
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        cycle();
        checks++;
        if (s_req_valid !== 1'b1) begin errors++; $display("FAIL bp_req_resume: got %b, required 1", s_req_valid); end
        end_drain("bp");
    endtask

    task automatic test_redirect();
        int n = 0;
        apply_reset();
        rsp_lat       = 4;
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
        while (acc_log.size() < 2 && n < 10) begin cycle(); n++; end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2000;
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1003;
        cycle();
        cycle();
        checks++;
        if (s_inst_valid !== 1'b0) begin errors++; $display("FAIL redir_q_empty: inst_valid=%b, required 0", s_inst_valid); end
        repeat (10) cycle();
        checks += 2;
        if (acc_log.size() < 3 || acc_log[2] !== 64'h1000) begin
            errors++;
            $display("FAIL redir_addr: got %h, required 1000", (acc_log.size() >= 3) ? acc_log[2] : 64'hx);
        end
        if (inst_log.size() < 1 || inst_log[0] !== 64'h1000) begin
            errors++;
            $display("FAIL redir_first_pc: got %h, required 1000", (inst_log.size() >= 1) ? inst_log[0] : 64'hx);
        end
        end_drain("redir");
    endtask

    task automatic test_fault();
        apply_reset();
        fault_addr    = 64'h108;
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
        repeat (9) cycle();
        checks += 4;
        if (fault_pc_seen !== 64'h108) begin errors++; $display("FAIL fault_pc: got %h, required 108", fault_pc_seen); end
        if (fault_word_seen !== 32'h0) begin errors++; $display("FAIL fault_word: got %h, required 0", fault_word_seen); end
        if (acc_log.size() != 4) begin errors++; $display("FAIL fault_accepts: got %0d, required 4", acc_log.size()); end
        if (s_req_valid !== 1'b0) begin errors++; $display("FAIL fault_halt: mem_req_valid=%b, required 0", s_req_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        cycle();
        cycle();
        checks++;
        if (acc_log.size() != 5 || acc_log[4] !== 64'h200) begin
            errors++;
            $display("FAIL fault_restart: got %h, required 200", (acc_log.size() >= 5) ? acc_log[4] : 64'hx);
        end
        end_drain("fault");
    endtask

    task automatic test_wrap();
        apply_reset();
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
        repeat (6) cycle();
        checks += 6;
        if (w_acc_log.size() < 2 || w_acc_log[0] !== 64'hFFFF_FFFF_FFFF_FFFC || w_acc_log[1] !== 64'h0) begin
            errors++;
            $display("FAIL wrap_addr: got %0d requests, first two required FFFFFFFFFFFFFFFC then 0", w_acc_log.size());
        end
        if (w_inst_log.size() < 1 || w_inst_log[0] !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_pc0: got %h, required FFFFFFFFFFFFFFFC", (w_inst_log.size() >= 1) ? w_inst_log[0] : 64'hx);
        end
        if (w_inst_log.size() < 2 || w_inst_log[1] !== 64'h0) begin
            errors++;
            $display("FAIL wrap_pc1: got %h, required 0", (w_inst_log.size() >= 2) ? w_inst_log[1] : 64'hx);
        end
        if (w_word_log.size() < 1 || w_word_log[0] !== word_of(64'h100)) begin
            errors++;
            $display("FAIL wrap_word0: got %h, required %h", (w_word_log.size() >= 1) ? w_word_log[0] : 32'hx, word_of(64'h100));
        end
        if (w_fault_seen !== 1'b0) begin errors++; $display("FAIL wrap_fault: got %b, required 0", w_fault_seen); end
        if (acc_log.size() < 1 || acc_log[0] !== 64'h100) begin
            errors++;
            $display("FAIL wrap_main_addr: got %h, required 100", (acc_log.size() >= 1) ? acc_log[0] : 64'hx);
        end
        end_drain("wrap");
    endtask

    task automatic test_latency();
        apply_reset();
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
        repeat (6) cycle();
        checks++;
        if (first_acc_cyc < 0 || first_inst_cyc < 0 || (first_inst_cyc - first_acc_cyc) != EXP_LAT) begin
            errors++;
            $display("FAIL issue_latency: got %0d cycles, required %0d", first_inst_cyc - first_acc_cyc, EXP_LAT);
        end
        end_drain("lat");
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 32'h0;
        mem_rsp_fault  = 1'b0;
        inst_ready     = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fault();
        test_wrap();
        test_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
